// File: rtl/chip8_video_pkg.sv
// chip8_video_pkg: shared video geometry constants and sprite blitter state encoding
package chip8_video_pkg;
  localparam int VRAM_W = 128;
  localparam int VRAM_H = 64;
  localparam int PIX_BITS = 2;
  localparam int BYTE_CYCLES = 18;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PADDR, S_PRMW, S_DONE} blit_state_t;
endpackage

// File: rtl/sprite_blitter_rmw.sv
// sprite_pixel_rmw: clip check, plane XOR and collision detect for one sprite pixel
module sprite_pixel_rmw
  import chip8_video_pkg::*;
#(
  parameter bit CLIP = 1'b1
) (
  input  logic                bit_set,
  input  logic                carry_x,
  input  logic                carry_y,
  input  logic [PIX_BITS-1:0] pixelo,
  input  logic [PIX_BITS-1:0] plane,
  output logic                we,
  output logic [PIX_BITS-1:0] pixeli,
  output logic                hit
);
  assign we = bit_set && !(CLIP && (carry_x || carry_y));
  assign pixeli = pixelo ^ plane;
  assign hit = we && |(pixelo & plane);
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: CHIP-8/SCHIP DXYN draw engine, fetches sprite bytes and XORs them into VRAM
module sprite_blitter
  import chip8_video_pkg::*;
#(
  parameter bit CLIP = 1'b1,
  parameter int RAM_AW = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          x,
  input  logic [7:0]          y,
  input  logic [3:0]          n,
  input  logic [RAM_AW-1:0]   i_addr,
  input  logic [PIX_BITS-1:0] plane,
  output logic                busy,
  output logic                done,
  output logic                collision,
  output logic [RAM_AW-1:0]   ram_addr,
  input  logic [7:0]          ram_dout,
  output logic [6:0]          vram_hpos,
  output logic [5:0]          vram_vpos,
  input  logic [PIX_BITS-1:0] vram_pixelo,
  output logic [PIX_BITS-1:0] vram_pixeli,
  output logic                vram_we
);
  blit_state_t state, state_n;
  logic [6:0] x0;
  logic [5:0] y0;
  logic [4:0] nrows, row;
  logic wide, byt;
  logic [2:0] col;
  logic [7:0] sr;
  logic [RAM_AW-1:0] base;
  logic [PIX_BITS-1:0] pl;
  logic [7:0] px;
  logic [6:0] py;
  logic px_we, px_hit, last, in_pix, unused;
  logic [PIX_BITS-1:0] px_val;
  assign unused = &{x[7], y[7:6]};
  assign px = {1'b0, x0} + {4'b0, byt, col};
  assign py = {1'b0, y0} + {2'b0, row};
  assign last = (byt == wide) && (row == nrows - 5'd1);
  assign in_pix = (state == S_PADDR) || (state == S_PRMW);
  // A 16-wide row holds two bytes, so {row,byt} is row*2+byte.
  assign ram_addr = (state == S_FETCH || state == S_LATCH) ?
                    base + (wide ? RAM_AW'({row, byt}) : RAM_AW'(row)) : '0;
  assign vram_hpos = in_pix ? px[6:0] : '0;
  assign vram_vpos = in_pix ? py[5:0] : '0;
  assign vram_we = (state == S_PRMW) && px_we;
  assign vram_pixeli = vram_we ? px_val : '0;
  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = state == S_DONE;
  sprite_pixel_rmw #(.CLIP(CLIP)) u_rmw (
    .bit_set(sr[7]),
    .carry_x(px[7]),
    .carry_y(py[6]),
    .pixelo (vram_pixelo),
    .plane  (pl),
    .we     (px_we),
    .pixeli (px_val),
    .hit    (px_hit)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      x0 <= '0;
      y0 <= '0;
      nrows <= '0;
      wide <= 1'b0;
      base <= '0;
      pl <= '0;
      row <= '0;
      byt <= 1'b0;
      col <= '0;
      sr <= '0;
      collision <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (start) begin
          x0 <= x[6:0];
          y0 <= y[5:0];
          nrows <= (n == 4'd0) ? 5'd16 : {1'b0, n};
          wide <= n == 4'd0;
          base <= i_addr;
          pl <= plane;
          collision <= 1'b0;
          row <= '0;
          byt <= 1'b0;
          col <= '0;
        end
        S_LATCH: sr <= ram_dout;
        S_PRMW: begin
          sr <= {sr[6:0], 1'b0};
          col <= col + 3'd1;
          collision <= collision | px_hit;
          if (col == 3'd7) begin
            byt <= wide & ~byt;
            if (!wide || byt) row <= row + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = !start ? S_IDLE : (plane == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_n = S_LATCH;
      S_LATCH: state_n = S_PADDR;
      S_PADDR: state_n = S_PRMW;
      S_PRMW:  state_n = (col != 3'd7) ? S_PADDR : last ? S_DONE : S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Executes the CHIP-8/SCHIP draw operation (DXYN) on behalf of the cpu.
- Fetches sprite bytes from the 4 KiB RAM and XORs the set sprite bits into the 128x64, 2-bit-per-pixel VRAM through its read-modify-write port. It reports pixel collision.
- Sits between the cpu sequencer and the VRAM. The cpu hands over a draw command and waits on busy/done instead of driving VRAM itself.

Parameters:
- CLIP, 1: 1 = pixels past the right or bottom edge are dropped; 0 = they wrap modulo screen size.
- RAM_AW, 12: RAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  draw request, sampled in IDLE only
- x  in  8  sprite X origin, used modulo 128
- y  in  8  sprite Y origin, used modulo 64
- n  in  4  row count; 0 = 16x16 SCHIP sprite
- i_addr  in  12  sprite base address (I register)
- plane  in  2  plane mask XORed into set pixels
- busy  out  1  high while a draw is in progress
- done  out  1  one-cycle pulse at draw completion
- collision  out  1  at least one plane bit turned from 1 to 0 during the last draw
- ram_addr  out  12  RAM read address
- ram_dout  in  8  RAM data, valid one cycle after ram_addr
- vram_hpos  out  7  VRAM column
- vram_vpos  out  6  VRAM row
- vram_pixelo  in  2  VRAM read data, valid one cycle after hpos/vpos
- vram_pixeli  out  2  VRAM write data
- vram_we  out  1  VRAM write enable

Behaviour:
- Reset, asynchronous, usable at any time including mid-draw:
  - state=IDLE.
  - busy, done, collision, vram_we = 0.
  - ram_addr, vram_hpos, vram_vpos, vram_pixeli = 0.
  - A partially drawn sprite is left as is. There is no rollback.
- Geometry:
  - If n==0: 16 rows, 2 bytes per row (B=2), 16 columns.
  - Otherwise: n rows, B=1, 8 columns.
  - The MSB of each byte is the leftmost pixel.
- Byte address = (i_addr + row*B + byte) mod 4096. It wraps silently.
- States: IDLE -> FETCH -> LATCH -> {PADDR -> PRMW} x8 -> (next byte: FETCH | last: DONE) -> IDLE.
- IDLE:
  - busy=0.
  - If start=1: latch x0 = x[6:0], y0 = y[5:0], n, i_addr and plane; clear collision; set row=0, byte=0.
  - If plane==0: go to DONE and draw nothing. Otherwise go to FETCH.
- FETCH: drive ram_addr for the current byte.
- LATCH: capture ram_dout into an 8-bit shift register.
- PADDR:
  - Pixel position: px = x0 + byte*8 + col (7-bit arithmetic plus carry); py = y0 + row (6-bit arithmetic plus carry).
  - Drive vram_hpos = px[6:0] and vram_vpos = py[5:0].
- PRMW:
  - Hold hpos/vpos unchanged from PADDR.
  - A pixel is "clipped" when CLIP=1 and the carry out of px or py is set.
  - If the sprite bit is 1 and the pixel is not clipped: vram_pixeli = vram_pixelo ^ plane, vram_we=1, and collision |= |(vram_pixelo & plane).
  - Otherwise vram_we=0. The cycle is still consumed, so timing is data-independent.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy is 1 in every state other than IDLE and DONE.
- vram_we is 1 only in PRMW.
- Latency:
  - start sampled at edge k.
  - DONE is the state during cycle k+1+R*B*18, where R = number of rows.
  - Plane 0: DONE during cycle k+1.
- collision holds its value from DONE until the next accepted start.
- start while busy or in DONE is ignored. No queueing.
- Origin beyond the screen (x >= 128, y >= 64) wraps before clipping is applied, per CHIP-8 semantics.
- ram_addr is don't-care outside FETCH/LATCH. vram_hpos/vram_vpos are don't-care outside PADDR/PRMW.

Decomposition:
- Shared package chip8_video_pkg holds:
  - constants VRAM_W=128, VRAM_H=64, PIX_BITS=2, BYTE_CYCLES=18
  - the blitter state enum
- Optional sub-module sprite_pixel_rmw: combinational clip check, XOR and collision detect for one pixel.
- The FSM and counters stay in sprite_blitter.

Test Plan:
- Blank VRAM, RAM[0x200]=0xF0, x=0, y=0, n=1, plane=3 -> pixels (0..3,0)=3 and (4..7,0)=0; collision=0; done exactly 18 cycles after start.
- Repeat the same draw -> pixels (0..3,0)=0; collision=1; no other VRAM writes.
- CLIP=1, x=124, y=63, n=2, bytes 0xFF,0xFF -> only (124..127,63) written; row 64 absent. CLIP=0 -> also (0..3,63), (124..127,0) and (0..3,0) written.
- x=130, y=70, n=1, byte 0x80 -> pixel (2,6) toggled. Plane=1 over an existing value 2 -> result 3, collision=0.
- n=0, i_addr=0xFFF -> 32 RAM reads at 0xFFF, 0x000 ... 0x01E; 16x16 block drawn; done after 16*2*18=576 cycles. start pulses during busy are ignored.
- Assert reset during the 5th pixel of row 0 -> busy, done, vram_we drop immediately. A new start after release draws normally.
